// File: rtl/fu_mc_if.sv
// Request/response bundle for the fu_mc multi-cycle function unit.
// master = control unit / register-file side, slave = the function unit.
interface fu_mc_if #(
  parameter int DW = 16
);
  logic          start_in;
  logic [3:0]    fs_in;
  logic [DW-1:0] a_in;
  logic [DW-1:0] b_in;
  logic          ready_out;
  logic          done_out;
  logic [DW-1:0] f_out;
  logic          z_out;
  logic          n_out;
  logic          v_out;

  modport master (
    output start_in, fs_in, a_in, b_in,
    input  ready_out, done_out, f_out, z_out, n_out, v_out
  );

  modport slave (
    input  start_in, fs_in, a_in, b_in,
    output ready_out, done_out, f_out, z_out, n_out, v_out
  );
endinterface

// File: rtl/fu_mc.sv
// Multi-cycle function unit: single-cycle ALU ops plus an iterative shift-add MUL.
// Define FU_MC_MUL_SAT_EN to saturate MUL results on overflow instead of truncating.
module fu_mc #(
  parameter int DW = 16
) (
  input  logic   clk,
  input  logic   rst,
  fu_mc_if.slave bus
);

  localparam int CW = $clog2(DW + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic [3:0] FS_MOVA = 4'd0;
  localparam logic [3:0] FS_INC  = 4'd1;
  localparam logic [3:0] FS_DEC  = 4'd2;
  localparam logic [3:0] FS_ADD  = 4'd3;
  localparam logic [3:0] FS_SUB  = 4'd4;
  localparam logic [3:0] FS_CLR  = 4'd5;
  localparam logic [3:0] FS_AND  = 4'd6;
  localparam logic [3:0] FS_OR   = 4'd7;
  localparam logic [3:0] FS_XOR  = 4'd8;
  localparam logic [3:0] FS_NOT  = 4'd9;
  localparam logic [3:0] FS_MOVB = 4'd10;
  localparam logic [3:0] FS_SHR  = 4'd11;
  localparam logic [3:0] FS_SHL  = 4'd12;
  localparam logic [3:0] FS_MUL  = 4'd13;

  logic [0:0]      r_state;
  logic [2*DW-1:0] r_mcand;
  logic [DW-1:0]   r_mplier;
  logic [2*DW-1:0] r_acc;
  logic [CW-1:0]   r_cnt;
  logic [DW-1:0]   r_f;
  logic            r_z;
  logic            r_n;
  logic            r_v;
  logic            r_done;

  logic [DW:0]     w_alu;
  logic [2*DW-1:0] w_acc_next;
  logic            w_mul_ovf;
  logic [DW-1:0]   w_mul_f;
  logic            w_accept;
  logic            w_mul_start;
  logic            w_mul_last;
  logic            w_complete;
  logic [DW-1:0]   w_fin_f;
  logic            w_fin_v;

  // Single-cycle ops: w_alu[DW] carries the v flag, w_alu[DW-1:0] the result.
  always_comb begin
    w_alu = '0;
    case (bus.fs_in)
      FS_MOVA: w_alu = {1'b0, bus.a_in};
      FS_INC:  w_alu = {1'b0, bus.a_in} + (DW+1)'(1);
      FS_DEC:  w_alu = {1'b0, bus.a_in} - (DW+1)'(1);
      FS_ADD:  w_alu = {1'b0, bus.a_in} + {1'b0, bus.b_in};
      FS_SUB:  w_alu = {1'b0, bus.a_in} - {1'b0, bus.b_in};
      FS_CLR:  w_alu = '0;
      FS_AND:  w_alu = {1'b0, bus.a_in & bus.b_in};
      FS_OR:   w_alu = {1'b0, bus.a_in | bus.b_in};
      FS_XOR:  w_alu = {1'b0, bus.a_in ^ bus.b_in};
      FS_NOT:  w_alu = {1'b0, ~bus.a_in};
      FS_MOVB: w_alu = {1'b0, bus.b_in};
      FS_SHR:  w_alu = {bus.b_in[0], 1'b0, bus.b_in[DW-1:1]};
      FS_SHL:  w_alu = {bus.b_in[DW-1], bus.b_in[DW-2:0], 1'b0};
      default: w_alu = '0;
    endcase
  end

  // The final partial product is folded in combinationally so the result
  // registers on the same edge the counter reaches zero.
  always_comb begin
    w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    w_mul_ovf  = |w_acc_next[2*DW-1:DW];
`ifdef FU_MC_MUL_SAT_EN
    w_mul_f    = w_mul_ovf ? '1 : w_acc_next[DW-1:0];
`else
    w_mul_f    = w_acc_next[DW-1:0];
`endif
  end

  always_comb begin
    w_accept    = bus.start_in && (r_state == S_IDLE);
    w_mul_start = w_accept && (bus.fs_in == FS_MUL);
    w_mul_last  = (r_state == S_BUSY) && (r_cnt == CW'(1));
    w_complete  = (w_accept && !w_mul_start) || w_mul_last;
    w_fin_f     = w_mul_last ? w_mul_f   : w_alu[DW-1:0];
    w_fin_v     = w_mul_last ? w_mul_ovf : w_alu[DW];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_f      <= '0;
      r_z      <= 1'b0;
      r_n      <= 1'b0;
      r_v      <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_complete;
      if (w_complete) begin
        r_f <= w_fin_f;
        r_z <= (w_fin_f == '0);
        r_n <= w_fin_f[DW-1];
        r_v <= w_fin_v;
      end
      case (r_state)
        S_IDLE: begin
          if (w_mul_start) begin
            r_mcand  <= {{DW{1'b0}}, bus.a_in};
            r_mplier <= bus.b_in;
            r_acc    <= '0;
            r_cnt    <= CW'(DW);
            r_state  <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt - CW'(1);
          if (w_mul_last) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ready_out = (r_state == S_IDLE);
  assign bus.done_out  = r_done;
  assign bus.f_out     = r_f;
  assign bus.z_out     = r_z;
  assign bus.n_out     = r_n;
  assign bus.v_out     = r_v;

endmodule

// File: tb/tb_fu_mc.sv
// Scoreboard bench for fu_mc: driver pushes reference results, monitor checks on done_out.
module tb_fu_mc;
  localparam int DW = 16;
  localparam longint unsigned M = 64'd1 << DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fu_mc_if #(.DW(DW)) bus ();
  fu_mc #(.DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [DW-1:0] f;
    logic          z;
    logic          n;
    logic          v;
    int            due;
  } exp_t;

  int   checks  = 0;
  int   errors  = 0;
  int   cyc     = 0;
  int   mul_due = 0;
  exp_t q[$];
  exp_t hold;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model straight from the opcode table, using wide integer arithmetic.
  function automatic exp_t model(input logic [3:0] fs, input logic [DW-1:0] a, input logic [DW-1:0] b);
    longint unsigned ua;
    longint unsigned ub;
    longint unsigned r;
    logic v;
    exp_t e;
    ua = a; ub = b; r = 0; v = 1'b0;
    case (fs)
      4'd0:  r = ua;
      4'd1:  begin r = ua + 1; v = (r >= M); end
      4'd2:  begin v = (ua == 0); r = ua + M - 1; end
      4'd3:  begin r = ua + ub; v = (r >= M); end
      4'd4:  begin v = (ua < ub); r = ua + M - ub; end
      4'd5:  r = 0;
      4'd6:  r = ua & ub;
      4'd7:  r = ua | ub;
      4'd8:  r = ua ^ ub;
      4'd9:  r = (M - 1) - ua;
      4'd10: r = ub;
      4'd11: begin r = ub / 2; v = (ub % 2 == 1); end
      4'd12: begin r = ub * 2; v = (ub >= M / 2); end
      4'd13: begin
        r = ua * ub;
        v = (r >= M);
`ifdef FU_MC_MUL_SAT_EN
        if (v) r = M - 1;
`endif
      end
      default: r = 0;
    endcase
    e.f   = DW'(r % M);
    e.z   = (e.f == '0);
    e.n   = e.f[DW-1];
    e.v   = v;
    e.due = 0;
    return e;
  endfunction

  function automatic logic [DW-1:0] pick();
    logic [DW-1:0] r;
    r = DW'($urandom);
    case ($urandom_range(0, 7))
      0: r = '0;
      1: r = '1;
      2: r = DW'(1);
      3: r = {1'b1, {(DW-1){1'b0}}};
      default: ;
    endcase
    return r;
  endfunction

  // Monitor: compare on every done_out, otherwise verify outputs hold.
  always @(negedge clk) begin
    exp_t e;
    if (bus.done_out === 1'b1) begin
      if (q.size() == 0) begin
        chk("spurious_done", bus.done_out, 1'b0);
      end else begin
        e = q.pop_front();
        chk("done_cycle", cyc, e.due);
        chk("f", bus.f_out, e.f);
        chk("z", bus.z_out, e.z);
        chk("n", bus.n_out, e.n);
        chk("v", bus.v_out, e.v);
        hold = e;
      end
    end else begin
      if (q.size() > 0 && q[0].due <= cyc) begin
        chk("missing_done", bus.done_out, 1'b1);
        e = q.pop_front();
      end
      chk("hold_f", bus.f_out, hold.f);
      chk("hold_z", bus.z_out, hold.z);
      chk("hold_n", bus.n_out, hold.n);
      chk("hold_v", bus.v_out, hold.v);
    end
  end

  // Waits for ready (driving ignored junk while busy), then issues one request.
  task automatic issue(input logic [3:0] fs, input logic [DW-1:0] a, input logic [DW-1:0] b);
    exp_t e;
    bit   sent;
    sent = 1'b0;
    for (int t = 0; t < 100 && !sent; t++) begin
      @(negedge clk);
      chk("ready", bus.ready_out, (cyc >= mul_due));
      if (bus.ready_out === 1'b1) begin
        bus.start_in = 1'b1;
        bus.fs_in    = fs;
        bus.a_in     = a;
        bus.b_in     = b;
        e     = model(fs, a, b);
        e.due = cyc + 1 + ((fs == 4'd13) ? DW : 0);
        if (fs == 4'd13) mul_due = e.due;
        q.push_back(e);
        sent = 1'b1;
      end else begin
        bus.start_in = 1'($urandom_range(0, 1));
        bus.fs_in    = 4'($urandom_range(0, 15));
        bus.a_in     = DW'($urandom);
        bus.b_in     = DW'($urandom);
      end
    end
    if (!sent) chk("issue_timeout", bus.ready_out, 1'b1);
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      chk("ready", bus.ready_out, (cyc >= mul_due));
      bus.start_in = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst          = 1'b1;
    bus.start_in = 1'b0;
    q.delete();
    hold    = '{f: '0, z: 1'b0, n: 1'b0, v: 1'b0, due: 0};
    mul_due = 0;
    #1;
    chk("rst_ready", bus.ready_out, 1'b1);
    chk("rst_done", bus.done_out, 1'b0);
    chk("rst_f", bus.f_out, '0);
    chk("rst_z", bus.z_out, 1'b0);
    chk("rst_n", bus.n_out, 1'b0);
    chk("rst_v", bus.v_out, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] fs;
    hold         = '{f: '0, z: 1'b0, n: 1'b0, v: 1'b0, due: 0};
    bus.start_in = 1'b0;
    bus.fs_in    = '0;
    bus.a_in     = '0;
    bus.b_in     = '0;
    do_reset();

    issue(4'd3, 16'hFFFF, 16'h0001);
    issue(4'd4, 16'd5, 16'd7);
    issue(4'd6, 16'h0F0F, 16'h00FF);
    gap(2);
    issue(4'd13, 16'h00FF, 16'h0101);
    issue(4'd13, 16'd300, 16'd300);
    issue(4'd3, 16'h1234, 16'h4321);
    gap(1);

    issue(4'd13, 16'h1234, 16'h5678);
    gap(5);
    do_reset();
    gap(DW + 2);
    issue(4'd0, 16'h0000, DW'($urandom));
    issue(4'd11, DW'($urandom), 16'h0001);
    issue(4'd12, DW'($urandom), 16'h8000);
    issue(4'd14, DW'($urandom), DW'($urandom));
    issue(4'd2, 16'h0000, 16'h0000);
    issue(4'd1, 16'hFFFF, 16'h0000);
    gap(1);

    for (int i = 0; i < 300; i++) begin
      fs = 4'($urandom_range(0, 15));
      issue(fs, pick(), pick());
      if ($urandom_range(0, 5) == 0) gap($urandom_range(1, 3));
      if ($urandom_range(0, 79) == 0) begin
        gap($urandom_range(0, 4));
        do_reset();
      end
    end

    gap(DW + 3);
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fu_mc.md
# fu_mc

Parametrised multi-cycle function unit for the mycpu datapath, successor to the single-cycle 16-bit FU. Executes the 4-bit function-select set on two DW-bit operands behind a start/ready/done handshake. Every operation has a registered result and uniform Z/N/V flags. FMUL is a real iterative shift-add multiplier instead of an unfinished stub. Sits between the register-file read ports and the write-back mux; the control unit stalls on `ready_out`.

## Interface
Parameters:
- `DW`, 16: operand/result width; legal range ≥ 4.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `start_in`, in, 1: operation request; sampled only while `ready_out`=1.
- `fs_in`, in, 4: function select, sampled together with `start_in`.
- `a_in`, in, DW: operand A, sampled together with `start_in`.
- `b_in`, in, DW: operand B, sampled together with `start_in`.
- `ready_out`, out, 1: unit can accept a request this cycle.
- `done_out`, out, 1: one-cycle pulse; result and flags are valid from this cycle.
- `f_out`, out, DW: registered result; holds its value until the next completion.
- `z_out`, out, 1: `f_out`==0.
- `n_out`, out, 1: `f_out[DW-1]`.
- `v_out`, out, 1: unsigned carry, borrow or overflow of the completed operation.

## Operation
Function-select encoding:
- 0 MOVA: A.
- 1 INC: A+1, v=carry.
- 2 DEC: A−1, v=borrow.
- 3 ADD: A+B, v=carry.
- 4 SUB: A−B, v=borrow (set when A<B).
- 5 CLR: 0.
- 6 AND, 7 OR, 8 XOR: bitwise A op B.
- 9 NOT: ~A.
- 10 MOVB: B.
- 11 SHR: B>>1 (logical), v=B[0].
- 12 SHL: B<<1, v=B[DW-1].
- 13 MUL: unsigned A×B.
- 14, 15 reserved: f=0, v=0; complete like single-cycle ops.

Flag rules:
- v=0 for every op not listed above with a v rule.
- z and n are always derived from the final registered `f_out`, for every op including CLR and MUL.
- Arithmetic is modulo 2^DW except MUL (see Configuration).

State machine:
- IDLE: `ready_out`=1.
  - A request is accepted when `start_in` and `ready_out` are both 1.
  - Non-MUL op: registers result and flags at the accepting edge, pulses `done_out`, stays in IDLE.
  - MUL: latches A into a 2·DW-bit shifting multiplicand and B into a shifting multiplier, clears the 2·DW-bit accumulator, loads iteration counter = DW, moves to BUSY.
- BUSY: `ready_out`=0.
  - Each edge: if multiplier LSB=1, add the multiplicand to the accumulator; shift the multiplicand left and the multiplier right; decrement the counter.
  - On the edge where the counter goes 1→0: register the result and flags, pulse `done_out`, return to IDLE.
  - `start_in` is ignored in BUSY, and `fs_in`/`a_in`/`b_in` changes have no effect.
- MUL overflow is defined as accumulator[2·DW-1:DW] ≠ 0.

Reset:
- Asserting `rst` at any time, including mid-MUL, forces IDLE.
- `ready_out`=1; `done_out`=0; `f_out`=0; `z_out`=0; `n_out`=0; `v_out`=0; counter and accumulator cleared.
- An aborted MUL never produces `done_out`.

## Timing
- Non-MUL latency 1: request accepted at edge k gives `done_out`=1 and the new result from just after edge k.
- `ready_out` stays high on non-MUL ops, so back-to-back requests complete every cycle.
- MUL latency DW+1 edges: accept at edge k; `ready_out`=0 after edge k; `done_out`=1 and `ready_out`=1 after edge k+DW.
- A new request may be accepted in the same cycle as the MUL `done_out`.
- `done_out` is never high for two consecutive cycles from a single request.
- Between completions, `f_out`/`z_out`/`n_out`/`v_out` hold their values; `done_out`=0.

## Configuration
- Macro `FU_MC_MUL_SAT_EN`.
  - Defined: on MUL overflow, `f_out` saturates to all-ones and `v_out`=1.
  - Undefined: `f_out` = accumulator[DW-1:0] (truncated) and `v_out`=1 on overflow.
- In both builds, the non-overflow MUL result and all other ops are identical.

## Test plan
- ADD, DW=16, A=0xFFFF, B=0x0001: next cycle f=0x0000, z=1, n=0, v=1, `done_out` one-cycle pulse, `ready_out` stays 1.
- SUB, A=5, B=7: f=0xFFFE, z=0, n=1, v=1. Then back-to-back AND 0x0F0F & 0x00FF on the following cycle: f=0x000F, v=0, a second `done_out` pulse.
- MUL 0x00FF×0x0101: `ready_out` low for 16 cycles; `done_out` after edge k+16; f=0xFFFF, n=1, v=0. `start_in`=1 with fs=ADD asserted during BUSY: ignored, no extra `done_out`.
- MUL 300×300 (=90000):
  - With `FU_MC_MUL_SAT_EN`: f=0xFFFF, v=1.
  - Without it: f=0x5F90, v=1, z=0.
- `rst` pulsed 5 cycles into a MUL: `ready_out`=1, f=0, all flags 0, no `done_out` afterwards. A subsequent MOVA 0x0000 gives z=1.
- SHR B=0x0001 gives f=0, z=1, v=1. SHL B=0x8000 gives f=0, z=1, v=1. Reserved fs=14 gives f=0, z=1, v=0 with latency 1.
